// File: rtl/analog_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// analog_ctrl_pkg
// Shared definitions for the dual-slope conversion sequencer:
//   - state_e : FSM state encoding used by conv_sequencer
//   - ERR_*   : result error codes driven on err_o (code 3 is reserved)
//   - is_result_state() : true for states that present a result to the host
// -----------------------------------------------------------------------------
package analog_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_REF  = 3'd1,
    ST_AUTOZERO  = 3'd2,
    ST_INTEGRATE = 3'd3,
    ST_DEINT     = 3'd4,
    ST_DONE      = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_REF  = 2'd1;
  localparam logic [1:0] ERR_OVR  = 2'd2;

  function automatic logic is_result_state(input state_e s);
    return (s == ST_DONE) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable CNT_WIDTH up/down counter used to time every sequencer phase.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-low reset, clears the count
//   load_i     : load load_val_i (has priority over counting)
//   load_val_i : value to load
//   en_i       : count enable
//   up_i       : 1 = increment, 0 = decrement
//   cnt_o      : current count
//   tc_o       : terminal-count flag, high when the count is zero
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 en_i,
  input  logic                 up_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 tc_o
);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      if (up_i) cnt_q <= cnt_q + 1'b1;
      else      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/conv_sequencer.sv
// -----------------------------------------------------------------------------
// conv_sequencer
// Dual-slope ADC conversion sequencer: waits for the reference, auto-zeroes,
// integrates the input for a fixed time, then de-integrates against the
// reference of opposite polarity while counting clocks until the comparator
// crosses. The count, input sign and an error code are presented through a
// valid/ready handshake.
//
// Ports:
//   clk_i          : clock, rising edge
//   rst_i          : synchronous active-low reset (same effect as abort_i)
//   comp_i         : comparator output (1 = integrator above zero)
//   sat_hi_i/lo_i  : integrator saturation flags
//   ref_ok_i       : reference voltage good
//   start_i        : start a conversion (accepted only in IDLE)
//   abort_i        : cancel, return to IDLE next cycle (highest priority)
//   az_sw_o        : auto-zero switch
//   int_sw_o       : signal-integrate switch
//   ref_pos_o      : positive reference switch (de-integrate a negative input)
//   ref_neg_o      : negative reference switch (de-integrate a positive input)
//   busy_o         : not in IDLE
//   result_valid_o : result available (DONE or FAULT)
//   result_ready_i : host accepts result
//   count_o        : de-integrate clock count (0 on fault)
//   sign_o         : input polarity latched at end of integrate (1 = positive)
//   err_o          : ERR_NONE / ERR_REF / ERR_OVR
//
// Build option: define CONV_SAT_ABORT_EN to treat sat_hi_i/sat_lo_i during
// INTEGRATE or DEINT as an overrange fault. Without it those inputs are
// ignored and overrange is detected only by the DEINT_MAX limit.
//
// All outputs are registered from the next state, so every output lines up
// with the state register cycle for cycle.
// -----------------------------------------------------------------------------
module conv_sequencer
  import analog_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int AZ_CYCLES   = 2000,
  parameter int INT_CYCLES  = 10000,
  parameter int DEINT_MAX   = 20000,
  parameter int REF_TIMEOUT = 4095
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 comp_i,
  input  logic                 sat_hi_i,
  input  logic                 sat_lo_i,
  input  logic                 ref_ok_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 az_sw_o,
  output logic                 int_sw_o,
  output logic                 ref_pos_o,
  output logic                 ref_neg_o,
  output logic                 busy_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 sign_o,
  output logic [1:0]           err_o
);

  // Down-counted phases load N-1 so that the phase lasts exactly N clocks
  // (the terminal cycle is the one where the count reads zero).
  localparam logic [CNT_WIDTH-1:0] REF_LOAD   = CNT_WIDTH'(REF_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] AZ_LOAD    = CNT_WIDTH'(AZ_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] INT_LOAD   = CNT_WIDTH'(INT_CYCLES - 1);
  // Last DEINT cycle: incrementing past it would reach DEINT_MAX.
  localparam logic [CNT_WIDTH-1:0] DEINT_LAST = CNT_WIDTH'(DEINT_MAX - 1);

  state_e               state_q, state_d;
  logic                 sign_q, sign_d;
  logic [CNT_WIDTH-1:0] res_count_q, res_count_d;
  logic                 res_sign_q, res_sign_d;
  logic [1:0]           res_err_q, res_err_d;

  logic az_sw_q, int_sw_q, ref_pos_q, ref_neg_q, busy_q, valid_q;

  logic                 tmr_load, tmr_en, tmr_up, tmr_tc;
  logic [CNT_WIDTH-1:0] tmr_val, tmr_cnt;
  logic                 sat_fault;

  phase_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .up_i       (tmr_up),
    .cnt_o      (tmr_cnt),
    .tc_o       (tmr_tc)
  );

`ifdef CONV_SAT_ABORT_EN
  assign sat_fault = (sat_hi_i || sat_lo_i) &&
                     ((state_q == ST_INTEGRATE) || (state_q == ST_DEINT));
`else
  logic unused_sat;
  assign unused_sat = sat_hi_i | sat_lo_i;
  assign sat_fault  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    res_count_d = res_count_q;
    res_sign_d  = res_sign_q;
    res_err_d   = res_err_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_en      = 1'b0;
    tmr_up      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_WAIT_REF;
          tmr_load = 1'b1;
          tmr_val  = REF_LOAD;
        end
      end
      ST_WAIT_REF: begin
        if (ref_ok_i) begin
          state_d  = ST_AUTOZERO;
          tmr_load = 1'b1;
          tmr_val  = AZ_LOAD;
        end else if (tmr_tc) begin
          state_d     = ST_FAULT;
          res_count_d = '0;
          res_sign_d  = 1'b0;
          res_err_d   = ERR_REF;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_AUTOZERO: begin
        if (tmr_tc) begin
          state_d  = ST_INTEGRATE;
          tmr_load = 1'b1;
          tmr_val  = INT_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_INTEGRATE: begin
        if (tmr_tc) begin
          state_d  = ST_DEINT;
          sign_d   = comp_i;
          tmr_load = 1'b1;
          tmr_val  = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DEINT: begin
        // A crossing is checked before the limit so that a crossing on the
        // final allowed cycle still yields a valid result.
        if (comp_i != sign_q) begin
          state_d     = ST_DONE;
          res_count_d = tmr_cnt;
          res_sign_d  = sign_q;
          res_err_d   = ERR_NONE;
        end else if (tmr_cnt == DEINT_LAST) begin
          state_d     = ST_FAULT;
          res_count_d = '0;
          res_sign_d  = 1'b0;
          res_err_d   = ERR_OVR;
        end else begin
          tmr_en = 1'b1;
          tmr_up = 1'b1;
        end
      end
      ST_DONE, ST_FAULT: begin
        if (result_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (sat_fault) begin
      state_d     = ST_FAULT;
      res_count_d = '0;
      res_sign_d  = 1'b0;
      res_err_d   = ERR_OVR;
    end

    if (abort_i) state_d = ST_IDLE;

    // The payload is only meaningful while a result is offered.
    if (state_d == ST_IDLE) begin
      sign_d      = 1'b0;
      res_count_d = '0;
      res_sign_d  = 1'b0;
      res_err_d   = ERR_NONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      res_count_q <= '0;
      res_sign_q  <= 1'b0;
      res_err_q   <= ERR_NONE;
      az_sw_q     <= 1'b0;
      int_sw_q    <= 1'b0;
      ref_pos_q   <= 1'b0;
      ref_neg_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      res_count_q <= res_count_d;
      res_sign_q  <= res_sign_d;
      res_err_q   <= res_err_d;
      az_sw_q     <= (state_d == ST_AUTOZERO);
      int_sw_q    <= (state_d == ST_INTEGRATE);
      ref_neg_q   <= (state_d == ST_DEINT) &&  sign_d;
      ref_pos_q   <= (state_d == ST_DEINT) && !sign_d;
      busy_q      <= (state_d != ST_IDLE);
      valid_q     <= is_result_state(state_d);
    end
  end

  assign az_sw_o        = az_sw_q;
  assign int_sw_o       = int_sw_q;
  assign ref_pos_o      = ref_pos_q;
  assign ref_neg_o      = ref_neg_q;
  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign count_o        = res_count_q;
  assign sign_o         = res_sign_q;
  assign err_o          = res_err_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_sequencer
// Self-checking bench for conv_sequencer with AZ_CYCLES=4, INT_CYCLES=10,
// DEINT_MAX=30, REF_TIMEOUT=8. A table of conversion scenarios is run in a
// loop; expected results go into a scoreboard queue at start and are popped
// when result_valid_o rises. Hand-written sequences cover result hold,
// abort in INTEGRATE and reset in DEINT.
// -----------------------------------------------------------------------------
module tb_conv_sequencer;

  localparam int CW         = 16;
  localparam int AZ         = 4;
  localparam int INTC       = 10;
  localparam int DMAX       = 30;
  localparam int RTO        = 8;
  // Edge (counted from the start-accept edge 0) after which DEINT begins.
  localparam int DEINT_EDGE = 1 + AZ + INTC;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          comp_i = 1'b0, sat_hi_i = 1'b0, sat_lo_i = 1'b0, ref_ok_i = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0, result_ready_i = 1'b0;
  logic          az_sw_o, int_sw_o, ref_pos_o, ref_neg_o, busy_o, result_valid_o;
  logic [CW-1:0] count_o;
  logic          sign_o;
  logic [1:0]    err_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [CW-1:0] count;
    logic          sign;
    logic [1:0]    err;
  } res_t;

  typedef struct {
    logic ref_ok;
    logic comp_pos;
    int   cross_at;   // DEINT clock at which comp_i flips, -1 = never
    int   sat_at;     // edge index after which sat_hi_i pulses, -1 = never
    int   exp_count;
    logic exp_sign;
    logic [1:0] exp_err;
    int   exp_az, exp_int, exp_neg, exp_pos;
    int   exp_lat;    // edge index at which result_valid_o is first seen
  } vec_t;

  res_t sb_q[$];
  vec_t vecs[7];

  conv_sequencer #(
    .CNT_WIDTH   (CW),
    .AZ_CYCLES   (AZ),
    .INT_CYCLES  (INTC),
    .DEINT_MAX   (DMAX),
    .REF_TIMEOUT (RTO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .comp_i         (comp_i),
    .sat_hi_i       (sat_hi_i),
    .sat_lo_i       (sat_lo_i),
    .ref_ok_i       (ref_ok_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .az_sw_o        (az_sw_o),
    .int_sw_o       (int_sw_o),
    .ref_pos_o      (ref_pos_o),
    .ref_neg_o      (ref_neg_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .count_o        (count_o),
    .sign_o         (sign_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {7'd0, az_sw_o, int_sw_o, ref_pos_o, ref_neg_o, busy_o,
            result_valid_o, sign_o, err_o, count_o};
  endfunction

  task automatic run_conv(input vec_t v, input int hold, input bit start_in_hold,
                          input string tag);
    int   az_n = 0, int_n = 0, neg_n = 0, pos_n = 0, onehot_bad = 0, lat = -1;
    res_t exp;
    exp.count = CW'(v.exp_count);
    exp.sign  = v.exp_sign;
    exp.err   = v.exp_err;
    sb_q.push_back(exp);

    ref_ok_i = v.ref_ok;
    comp_i   = v.comp_pos;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    check({tag, " busy"}, busy_o, 1);

    for (int n = 0; n < 200; n++) begin
      az_n  += int'(az_sw_o);
      int_n += int'(int_sw_o);
      neg_n += int'(ref_neg_o);
      pos_n += int'(ref_pos_o);
      if ((32'(az_sw_o) + 32'(int_sw_o) + 32'(ref_neg_o) + 32'(ref_pos_o)) > 1)
        onehot_bad++;
      if (result_valid_o) begin
        lat = n;
        break;
      end
      comp_i   = (v.cross_at >= 0 && n >= DEINT_EDGE + v.cross_at) ? ~v.comp_pos : v.comp_pos;
      sat_hi_i = (n == v.sat_at);
      tick();
    end
    sat_hi_i = 1'b0;

    check({tag, " latency"}, lat, v.exp_lat);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard"}, 0, 1);
    end else begin
      exp = sb_q.pop_front();
      if (lat >= 0) begin
        check({tag, " count"}, count_o, exp.count);
        check({tag, " err"}, err_o, exp.err);
        if (exp.err == 2'd0) check({tag, " sign"}, sign_o, exp.sign);
      end
    end
    check({tag, " az_cycles"},  az_n,  v.exp_az);
    check({tag, " int_cycles"}, int_n, v.exp_int);
    check({tag, " neg_cycles"}, neg_n, v.exp_neg);
    check({tag, " pos_cycles"}, pos_n, v.exp_pos);
    check({tag, " onehot"}, onehot_bad, 0);

    for (int h = 0; h < hold; h++) begin
      start_i = start_in_hold && (h == 5);
      tick();
      check({tag, " hold valid"}, result_valid_o, 1);
      check({tag, " hold count"}, count_o, exp.count);
      check({tag, " hold sign"},  sign_o,  exp.sign);
      check({tag, " hold err"},   err_o,   exp.err);
    end
    start_i = 1'b0;

    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check({tag, " released valid"}, result_valid_o, 0);
    check({tag, " released busy"},  busy_o, 0);
    comp_i = 1'b0;
  endtask

  // Start a normal conversion, then kill it after edge at_n with abort_i or rst_i.
  task automatic kill_conv(input bit use_rst, input int at_n, input string tag);
    int valid_seen = 0;
    ref_ok_i = 1'b1;
    comp_i   = 1'b1;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    for (int n = 0; n < at_n; n++) tick();
    if (use_rst) check({tag, " in deint"}, ref_neg_o, 1);
    else         check({tag, " in integrate"}, int_sw_o, 1);
    if (use_rst) rst_i = 1'b0;
    else         abort_i = 1'b1;
    tick();
    rst_i   = 1'b1;
    abort_i = 1'b0;
    check({tag, " outputs zero"}, all_outs(), 0);
    for (int n = 0; n < 60; n++) begin
      tick();
      valid_seen += int'(result_valid_o) + int'(busy_o);
    end
    check({tag, " stays idle"}, valid_seen, 0);
    check({tag, " no result queued"}, sb_q.size(), 0);
    comp_i = 1'b0;
  endtask

  initial begin
    //               ref cmp cross sat  cnt sgn err az int neg pos lat
    vecs[0] = '{1'b1, 1'b1, 7,  -1, 7,  1'b1, 2'd0, 4, 10, 8,  0,  23};
    vecs[1] = '{1'b0, 1'b1, -1, -1, 0,  1'b0, 2'd1, 0, 0,  0,  0,  8};
    vecs[2] = '{1'b1, 1'b0, -1, -1, 0,  1'b0, 2'd2, 4, 10, 0,  30, 45};
    vecs[3] = '{1'b1, 1'b0, 0,  -1, 0,  1'b0, 2'd0, 4, 10, 0,  1,  16};
    vecs[4] = '{1'b1, 1'b1, 29, -1, 29, 1'b1, 2'd0, 4, 10, 30, 0,  45};
    vecs[5] = '{1'b1, 1'b1, 30, -1, 0,  1'b0, 2'd2, 4, 10, 30, 0,  45};
`ifdef CONV_SAT_ABORT_EN
    vecs[6] = '{1'b1, 1'b1, 3,  8,  0,  1'b0, 2'd2, 4, 4,  0,  0,  9};
`else
    vecs[6] = '{1'b1, 1'b1, 3,  8,  3,  1'b1, 2'd0, 4, 10, 4,  0,  19};
`endif

    // Reset: held low with start asserted, everything must stay zero.
    rst_i   = 1'b0;
    start_i = 1'b1;
    tick();
    tick();
    check("reset outputs", all_outs(), 0);
    start_i = 1'b0;
    rst_i   = 1'b1;
    tick();
    check("idle after reset", all_outs(), 0);

    for (int i = 0; i < 7; i++)
      run_conv(vecs[i], 0, 1'b0, $sformatf("vec%0d", i));

    run_conv(vecs[0], 20, 1'b1, "hold");
    check("hold start ignored", busy_o, 0);

    kill_conv(1'b0, 8, "abort");
    kill_conv(1'b1, 20, "rst");

    run_conv(vecs[0], 0, 1'b0, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of phase counter and result count.
REQ-002 Parameter AZ_CYCLES, default 2000: auto-zero phase length in clocks.
REQ-003 Parameter INT_CYCLES, default 10000: fixed signal-integrate phase length in clocks.
REQ-004 Parameter DEINT_MAX, default 20000: de-integrate cycle limit before overrange.
REQ-005 Parameter REF_TIMEOUT, default 4095: maximum clocks to wait for ref_ok_i.
REQ-006 Port clk_i, input, 1: single clock; all logic rising-edge.
REQ-007 Port rst_i, input, 1: reset, synchronous, active-low.
REQ-008 Ports comp_i, sat_hi_i, sat_lo_i, ref_ok_i, input, 1 each: sanitized front-end status, already synchronous to clk_i.
REQ-009 Ports start_i and abort_i, input, 1 each: start conversion and cancel conversion.
REQ-010 Ports az_sw_o, int_sw_o, ref_pos_o, ref_neg_o, output, 1 each: registered analog switch drives.
REQ-011 Port busy_o, output, 1: high in any state other than IDLE.
REQ-012 Ports result_valid_o (output, 1) and result_ready_i (input, 1): result handshake.
REQ-013 Ports count_o (output, CNT_WIDTH), sign_o (output, 1) and err_o (output, 2): result payload.

Function
REQ-014 States: IDLE, WAIT_REF, AUTOZERO, INTEGRATE, DEINT, DONE, FAULT.
REQ-015 In IDLE, start_i high moves to WAIT_REF on the next cycle; start_i is ignored in all other states.
REQ-016 WAIT_REF: ref_ok_i high moves to AUTOZERO; REF_TIMEOUT clocks without ref_ok_i moves to FAULT with err_o=1.
REQ-017 AUTOZERO: az_sw_o is high for exactly AZ_CYCLES clocks, then the block moves to INTEGRATE.
REQ-018 INTEGRATE: int_sw_o is high for exactly INT_CYCLES clocks; comp_i sampled on the last cycle is latched as sign_o (1 = positive input).
REQ-019 DEINT: ref_neg_o is high when sign=1 and ref_pos_o is high when sign=0; the counter starts at 0 and increments each clock.
REQ-020 DEINT ends when comp_i != latched sign: count_o = completed DEINT clocks, err_o=0, next state DONE.
REQ-021 If the counter reaches DEINT_MAX without a crossing, the block moves to FAULT with err_o=2.
REQ-022 At most one switch output is high in any cycle; all switch outputs are low in IDLE, WAIT_REF, DONE and FAULT.
REQ-023 DONE/FAULT: result_valid_o is high and payload stable until a cycle with result_ready_i high, then the block moves to IDLE; FAULT drives count_o=0.
REQ-024 abort_i high in any state moves to IDLE on the next cycle, with switches low, result_valid_o low and no result produced; abort_i has priority over every other transition.
REQ-025 A comp_i crossing and DEINT_MAX reached in the same cycle resolves as a valid result (DONE).
REQ-026 err_o code 3 is reserved and never driven.

Reset
REQ-027 While rst_i is low at a clock edge, the block enters IDLE and clears the counter.
REQ-028 During reset, all switch outputs, busy_o, result_valid_o, count_o, sign_o and err_o are 0.
REQ-029 Reset mid-conversion behaves exactly as abort_i.

Configuration
REQ-030 Macro CONV_SAT_ABORT_EN defined: sat_hi_i or sat_lo_i high during INTEGRATE or DEINT moves to FAULT next cycle with err_o=2.
REQ-031 Macro CONV_SAT_ABORT_EN undefined: sat_hi_i and sat_lo_i are ignored; overrange is detected only via DEINT_MAX.

Structure
REQ-032 Package analog_ctrl_pkg holds the state encoding and the err_o code constants (ERR_NONE=0, ERR_REF=1, ERR_OVR=2).
REQ-033 One sub-module, phase_timer, provides a loadable CNT_WIDTH down/up counter with terminal-count flag; the FSM lives in conv_sequencer.

Verification (AZ_CYCLES=4, INT_CYCLES=10, DEINT_MAX=30, REF_TIMEOUT=8)
REQ-034 Bench covers: ref_ok_i=1, comp_i=1, start pulse, comp_i falls 7 clocks into DEINT -> az_sw_o high for 4 clocks, int_sw_o high for 10 clocks, ref_neg_o high, count_o=7, sign_o=1, err_o=0.
REQ-035 Bench covers: ref_ok_i held 0, start pulse -> FAULT after 8 clocks, err_o=1, no switch output ever high.
REQ-036 Bench covers: comp_i=0, never crosses -> ref_pos_o high for 30 clocks, err_o=2, count_o=0.
REQ-037 Bench covers: result_ready_i held 0 for 20 clocks after DONE -> result_valid_o and payload stable for all 20 clocks; a start_i pulse in that window is ignored.
REQ-038 Bench covers: abort_i in INTEGRATE, and separately rst_i low in DEINT -> IDLE next cycle, all outputs 0, no result_valid_o.
REQ-039 Bench covers: sat_hi_i pulse in INTEGRATE -> with CONV_SAT_ABORT_EN, FAULT with err_o=2; without it, the conversion completes normally.
